seq_detect_param: RTL
=====================

Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 5-bit "bbcbc" detector (0=b, 1=c).
- Pattern, pattern length and counter width are parameters.
- Overlapping vs non-overlapping detection is selected at run time.
- Provides both a Mealy (same-cycle) and a Moore (registered) match output, plus a saturating match counter with synchronous clear. Sits on any serial bit stream qualified by a valid strobe.

Parameters:
- PAT_LEN, 5, pattern length in bits (2..16).
- PAT, 5'b00101, pattern; PAT[PAT_LEN-1] is the first bit received, PAT[0] the last (default = b,b,c,b,c).
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in_bit; state advances only when high.
- in_bit  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled only on a completing match.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match_mealy  output  1  combinational: high when the current valid bit completes the pattern.
- match  output  1  registered (Moore): high for exactly one cycle after a completing bit is accepted.
- match_cnt  output  CNT_W  number of matches, saturating at all-ones.
- state_dbg  output  clog2(PAT_LEN+1)  current matched-prefix length, for debug.

Behaviour:
- Reset: rst_n low asynchronously forces st=0, match=0, match_cnt=0. Mealy output is 0 while st=0 unless a 1-bit match is possible (never, since PAT_LEN>=2).
- State st holds the number of pattern bits currently matched (0..PAT_LEN-1). This is a KMP automaton, so no partial match is ever lost.
- in_valid=0: st, match_cnt hold; match clears to 0 on next edge.
- in_valid=1 and in_bit equals expected bit PAT[PAT_LEN-1-st]:
  - if st<PAT_LEN-1, then st<=st+1.
  - otherwise it is a completing match: match_mealy=1 this cycle; next edge match<=1 and match_cnt increments; st<=border(PAT_LEN) if overlap=1, else st<=0.
- in_valid=1 and mismatch: st<=fallback(st,in_bit). This is the longest proper prefix of PAT that is a suffix of (matched prefix + in_bit); it can be nonzero.
- border(n): length of the longest proper prefix of the first n pattern bits that is also a suffix of them.
- Both border and fallback are elaboration-time constants from a function; there is no runtime table RAM.
- match_mealy is a pure function of in_valid, in_bit and st.
- match is high only in the cycle after a completing bit. Back-to-back matches (possible only in overlap mode with border=PAT_LEN-1) hold it high on consecutive cycles.
- Counter: saturating; at all-ones a further match leaves it unchanged. cnt_clr=1 clears on the next edge and wins over a simultaneous increment (result 0). cnt_clr does not affect st or match.
- overlap may change any cycle; only its value at the completing-bit edge matters.
- Reset mid-pattern discards partial progress; no match fires for bits straddling reset.
- Latency: Mealy 0 cycles, Moore 1 cycle from the completing in_valid edge.

Decomposition:
- Package seq_detect_pkg: function next_state(pat, len, st, bit) implementing KMP fallback; function border(pat, len); constant for state width (clog2(PAT_LEN+1)).
- No sub-module needed. Optionally split out sat_counter (CNT_W, inc, clr) for reuse in the other detectors.

Test Plan:
- Default params, overlap=0, valid bits 0,0,1,0,1 -> match_mealy=1 on 5th bit; match=1 the next cycle only; match_cnt=1; state_dbg returns to 0.
- Default params, bits 0,0,1,0,0,1,0,1 -> no match at bit 5 (st falls back to 2, not 0); match at bit 8; match_cnt=1.
- PAT_LEN=3, PAT=3'b101, bits 1,0,1,0,1: overlap=1 -> matches at bits 3 and 5, match_cnt=2; overlap=0 -> match at bit 3 only, match_cnt=1.
- Default params, bits 0,0,1,0 then in_valid=0 for 3 cycles then bit 1 -> state held at 4 during the gap; match fires after the 1; match_cnt=1.
- CNT_W=2, six complete default patterns -> match_cnt reads 1,2,3,3,3,3. Asserting cnt_clr in the same cycle as a completing bit -> match_cnt=0, match still pulses.
- Bits 0,0,1,0, then rst_n low for 1 cycle (asynchronous, mid-cycle), then bit 1 -> no match; match_cnt=0; state_dbg=0 immediately on reset assertion.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared helpers for the serial pattern detectors: state sizing and the
// elaboration-time KMP border / fallback functions.
package seq_detect_pkg;

    localparam int MAX_PAT_LEN = 16;

    typedef logic [MAX_PAT_LEN-1:0] pat_t;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Width needed to hold a matched-prefix length of 0..len.
    function automatic int state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Pattern bit at stream position pos (0 = first bit received).
    function automatic logic pat_bit(input pat_t pat, input int len, input int pos);
        int idx;
        idx = len - 1 - pos;
        return pat[idx[3:0]];
    endfunction

    // Longest proper prefix of the first n pattern bits that is also a suffix of them.
    function automatic int border(input pat_t pat, input int len, input int n);
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k < n; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (pat_bit(pat, len, j) != pat_bit(pat, len, n - k + j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

    // Longest pattern prefix (shorter than the full pattern) that ends the
    // string "first st pattern bits followed by b". Covers both the advance
    // and the mismatch fallback; the completing case is handled by the caller.
    function automatic int next_state(input pat_t pat, input int len, input int st, input logic b);
        int   best;
        int   pos;
        logic ok;
        logic sb;
        best = 0;
        for (int k = 1; k <= st + 1; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    pos = st + 1 - k + j;
                    sb  = (pos < st) ? pat_bit(pat, len, pos) : b;
                    if (sb != pat_bit(pat, len, j)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that dominates the increment.
module seq_detect_param_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised KMP serial pattern detector with Mealy and Moore match outputs,
// run-time overlap selection and a saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PAT     = 5'b00101,
    parameter int                 CNT_W   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic                                in_bit,
    input  logic                                overlap,
    input  logic                                cnt_clr,
    output logic                                match_mealy,
    output logic                                match,
    output logic [CNT_W-1:0]                    match_cnt,
    output logic [state_w(PAT_LEN)-1:0]         state_dbg
);

    localparam int SW = state_w(PAT_LEN);
    localparam int NS = 2 ** SW;

    localparam logic [SW-1:0] LAST_ST   = SW'(PAT_LEN - 1);
    localparam logic [SW-1:0] BORDER_ST = SW'(border(pat_t'(PAT), PAT_LEN, PAT_LEN));

    // Constant transition tables, padded to a power of two so any state code indexes safely.
    logic          exp_tbl [NS];
    logic [SW-1:0] fb0_tbl [NS];
    logic [SW-1:0] fb1_tbl [NS];

    for (genvar s = 0; s < NS; s++) begin : g_tbl
        if (s < PAT_LEN) begin : g_live
            assign exp_tbl[s] = PAT[PAT_LEN-1-s];
            assign fb0_tbl[s] = SW'(next_state(pat_t'(PAT), PAT_LEN, s, 1'b0));
            assign fb1_tbl[s] = SW'(next_state(pat_t'(PAT), PAT_LEN, s, 1'b1));
        end else begin : g_pad
            assign exp_tbl[s] = 1'b0;
            assign fb0_tbl[s] = '0;
            assign fb1_tbl[s] = '0;
        end
    end

    logic [SW-1:0] st_q;
    logic [SW-1:0] st_d;
    logic          match_q;
    logic          match_d;
    logic          complete;

    assign complete = in_valid && (in_bit == exp_tbl[st_q]) && (st_q == LAST_ST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= '0;
            match_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        match_d = complete;
        if (in_valid) begin
            if (complete) begin
                st_d = (ovl_mode_e'(overlap) == OVL_ON) ? BORDER_ST : '0;
            end else if (in_bit) begin
                st_d = fb1_tbl[st_q];
            end else begin
                st_d = fb0_tbl[st_q];
            end
        end
    end

    always_comb begin
        match_mealy = complete;
        match       = match_q;
        state_dbg   = st_q;
    end

    seq_detect_param_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (complete),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

endmodule
